// File: rtl/jtag_tap_sequencer.sv
// ============================================================================
//  jtag_tap_sequencer : 1149.1 TAP controller with IR, bypass and chain strobes
//  Optional checks: define JTAG_TAP_SEQ_ASSERT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module jtag_tap_sequencer #(
  parameter int NCHAINS  = 4,
  parameter int IR_W     = 5,
  parameter int IR_RESET = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_tck_en,
  input  logic               io_tms,
  input  logic               io_tdi,
  output logic               io_tdo,
  output logic               io_tdo_en,
  output logic [NCHAINS-1:0] io_chainOut_capture,
  output logic [NCHAINS-1:0] io_chainOut_shift,
  output logic [NCHAINS-1:0] io_chainOut_update,
  output logic               io_chainOut_data,
  input  logic [NCHAINS-1:0] io_chainIn_data,
  output logic [IR_W-1:0]    io_ir,
  output logic [3:0]         io_state
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } state_e;

  localparam logic [IR_W-1:0] IR_RST = IR_W'(IR_RESET);
  localparam logic [IR_W-1:0] IR_CAP = IR_W'(1);

  state_e              state_q, state_d;
  logic [IR_W-1:0]     ir_q;
  logic [IR_W-1:0]     irsh_q;
  logic                bypass_q;
  logic [NCHAINS-1:0]  sel_oh;
  logic                sel_chain;
  logic                tck_act;

  for (genvar gi = 0; gi < NCHAINS; gi++) begin : g_chain_sel
    assign sel_oh[gi] = (ir_q == IR_W'(gi));
  end

  assign sel_chain = |sel_oh;
  // Gating with reset keeps chains from seeing a strobe on the reset edge.
  assign tck_act   = io_tck_en & ~reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = io_tms ? TLR    : RTI;
      RTI:    state_d = io_tms ? SEL_DR : RTI;
      SEL_DR: state_d = io_tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = io_tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = io_tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = io_tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = io_tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = io_tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = io_tms ? SEL_DR : RTI;
      SEL_IR: state_d = io_tms ? TLR    : CAP_IR;
      CAP_IR: state_d = io_tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = io_tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = io_tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = io_tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = io_tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = io_tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= TLR;
      ir_q     <= IR_RST;
      irsh_q   <= '0;
      bypass_q <= 1'b0;
    end else if (io_tck_en) begin
      state_q <= state_d;
      case (state_q)
        CAP_IR: irsh_q <= IR_CAP;
        SH_IR:  irsh_q <= {io_tdi, irsh_q[IR_W-1:1]};
        UPD_IR: ir_q   <= irsh_q;
        CAP_DR: if (!sel_chain) bypass_q <= 1'b0;
        SH_DR:  if (!sel_chain) bypass_q <= io_tdi;
        default: ;
      endcase
      if (state_d == TLR) ir_q <= IR_RST;
    end
  end

  assign io_chainOut_capture = (tck_act && state_q == CAP_DR) ? sel_oh : '0;
  assign io_chainOut_shift   = (tck_act && state_q == SH_DR)  ? sel_oh : '0;
  assign io_chainOut_update  = (tck_act && state_q == UPD_DR) ? sel_oh : '0;
  assign io_chainOut_data    = io_tdi;
  assign io_tdo_en           = (state_q == SH_DR) || (state_q == SH_IR);
  assign io_ir               = ir_q;
  assign io_state            = state_q;

  always_comb begin
    io_tdo = 1'b0;
    if (state_q == SH_IR)
      io_tdo = irsh_q[0];
    else if (state_q == SH_DR)
      io_tdo = sel_chain ? |(io_chainIn_data & sel_oh) : bypass_q;
  end

`ifdef JTAG_TAP_SEQ_ASSERT_EN
  state_e prev_state_q;
  logic   prev_tck_q;
  logic   prev_run_q;

  always_ff @(posedge clock) begin
    prev_state_q <= state_q;
    prev_tck_q   <= io_tck_en;
    prev_run_q   <= ~reset;
  end

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NCHAINS; i++) begin
        assert (!((io_chainOut_capture[i] & io_chainOut_shift[i]) |
                  (io_chainOut_capture[i] & io_chainOut_update[i]) |
                  (io_chainOut_shift[i]   & io_chainOut_update[i])))
        else begin
`ifndef SYNTHESIS
          $display("jtag_tap_sequencer: chain %0d strobes overlap", i);
`endif
        end
      end
      assert ($onehot0(io_chainOut_capture | io_chainOut_shift | io_chainOut_update))
      else begin
`ifndef SYNTHESIS
        $display("jtag_tap_sequencer: more than one chain strobe");
`endif
      end
      assert (!(prev_run_q && !prev_tck_q) || (state_q == prev_state_q))
      else begin
`ifndef SYNTHESIS
        $display("jtag_tap_sequencer: state moved without tck");
`endif
      end
    end
  end
`endif

endmodule

`default_nettype wire
